ipc_put: RTL and testbench

Transmit side of the tokenized IPC channel: FPGA logic pushes tokens into a local FIFO, and on a START strobe the block writes the queued tokens as one AXI4 INCR burst into the FPGA-to-host token area. The message is terminated with a single all-zero token. The block sits between the FPGA IPC handler and the AXI interconnect. It is a write-only AXI master with no read channels.

---
 rtl/ipc_put.sv | 149 ++++++++++++++
 tb/tb_ipc_put.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ipc_put.sv
// IPC transmit side: queues FPGA tokens in a FWFT FIFO and, on START, writes them
// as one AXI4 INCR burst terminated by a single all-zero token.
module ipc_put #(
   parameter int                    FIFO_DEPTH        = 512,
   parameter int                    TOKEN_WIDTH       = 32,
   parameter int                    ADDR_WIDTH        = 64,
   parameter int                    MAX_OUTPUT_TOKENS = 64,
   parameter logic [ADDR_WIDTH-1:0] TOKENS_ADDR       = '0
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          START,
   output logic                          IDLE,
   output logic                          DONE,
   output logic                          ERROR,
   input  logic [TOKEN_WIDTH-1:0]        FIFO_DATA,
   input  logic                          FIFO_WR_EN,
   output logic                          FIFO_FULL,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
   output logic [ADDR_WIDTH-1:0]         AXI_AWADDR,
   output logic                          AXI_AWVALID,
   output logic [7:0]                    AXI_AWLEN,
   output logic [2:0]                    AXI_AWSIZE,
   output logic [1:0]                    AXI_AWBURST,
   output logic [3:0]                    AXI_AWID,
   output logic [3:0]                    AXI_AWCACHE,
   output logic [2:0]                    AXI_AWPROT,
   output logic                          AXI_AWLOCK,
   output logic [3:0]                    AXI_AWQOS,
   input  logic                          AXI_AWREADY,
   output logic [TOKEN_WIDTH-1:0]        AXI_WDATA,
   output logic [TOKEN_WIDTH/8-1:0]      AXI_WSTRB,
   output logic                          AXI_WVALID,
   output logic                          AXI_WLAST,
   input  logic                          AXI_WREADY,
   input  logic [1:0]                    AXI_BRESP,
   input  logic                          AXI_BVALID,
   output logic                          AXI_BREADY
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int MAXN = MAX_OUTPUT_TOKENS - 1;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   state_t                 state_q, state_d;
   logic [7:0]             rem_q, rem_d;
   logic [7:0]             awlen_q, awlen_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic [CW-1:0]          count_q, count_d;
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [TOKEN_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic                   push, pop;
   logic [7:0]             n_beats;

   // Zero is the terminator, so it can never be queued as payload.
   assign FIFO_FULL  = (count_q == CW'(FIFO_DEPTH));
   assign push       = FIFO_WR_EN && (FIFO_DATA != '0) && !FIFO_FULL;
   assign FIFO_COUNT = count_q;

   always_comb begin
      n_beats = 8'(count_q);
      if (int'(count_q) > MAXN) n_beats = 8'(MAXN);
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      awlen_d = awlen_q;
      done_d  = 1'b0;
      error_d = error_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: if (START) begin
            awlen_d = n_beats;
            rem_d   = n_beats;
            state_d = S_ADDR;
         end
         S_ADDR: if (AXI_AWREADY) state_d = S_DATA;
         S_DATA: if (AXI_WREADY) begin
            if (rem_q != 8'd0) begin
               pop   = 1'b1;
               rem_d = rem_q - 8'd1;
            end else begin
               state_d = S_RESP;
            end
         end
         S_RESP: if (AXI_BVALID) begin
            error_d = (AXI_BRESP != 2'b00);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         awlen_q  <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         awlen_q  <= awlen_d;
         done_q   <= done_d;
         error_q  <= error_d;
         count_q  <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Storage needs no reset; flushing the pointers empties the FIFO.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= FIFO_DATA;
   end

   assign IDLE        = (state_q == S_IDLE) && !START;
   assign DONE        = done_q;
   assign ERROR       = error_q;
   assign AXI_AWADDR  = TOKENS_ADDR;
   assign AXI_AWVALID = (state_q == S_ADDR);
   assign AXI_AWLEN   = awlen_q;
   assign AXI_AWSIZE  = 3'($clog2(TOKEN_WIDTH/8));
   assign AXI_AWBURST = 2'd1;
   assign AXI_AWID    = 4'd1;
   assign AXI_AWCACHE = 4'd2;
   assign AXI_AWPROT  = 3'd0;
   assign AXI_AWLOCK  = 1'b0;
   assign AXI_AWQOS   = 4'd0;
   assign AXI_WVALID  = (state_q == S_DATA);
   assign AXI_WLAST   = (state_q == S_DATA) && (rem_q == 8'd0);
   assign AXI_WDATA   = (rem_q != 8'd0) ? mem_q[rd_ptr_q] : '0;
   assign AXI_WSTRB   = '1;
   assign AXI_BREADY  = (state_q == S_RESP);
endmodule

// File: tb/tb_ipc_put.sv
// Randomized scoreboard bench for ipc_put: a token-queue model predicts each burst,
// a negedge monitor checks AW/W/B traffic, DONE/ERROR and W stability.
module tb_ipc_put;
   localparam int          DEPTH = 16;
   localparam int          TW    = 32;
   localparam int          MAXT  = 8;
   localparam logic [63:0] BASE  = 64'h0000_0001_0000_1000;

   logic          clk = 0, resetn = 0, START = 0;
   logic          IDLE, DONE, ERROR, FIFO_FULL;
   logic [TW-1:0] FIFO_DATA = '0;
   logic          FIFO_WR_EN = 0;
   logic [4:0]    FIFO_COUNT;
   logic [63:0]   AXI_AWADDR;
   logic          AXI_AWVALID, AXI_AWLOCK, AXI_WVALID, AXI_WLAST, AXI_BREADY;
   logic [7:0]    AXI_AWLEN;
   logic [2:0]    AXI_AWSIZE, AXI_AWPROT;
   logic [1:0]    AXI_AWBURST;
   logic [3:0]    AXI_AWID, AXI_AWCACHE, AXI_AWQOS, AXI_WSTRB;
   logic          AXI_AWREADY = 0, AXI_WREADY = 0, AXI_BVALID = 0;
   logic [TW-1:0] AXI_WDATA;
   logic [1:0]    AXI_BRESP = 0;

   ipc_put #(.FIFO_DEPTH(DEPTH), .TOKEN_WIDTH(TW), .ADDR_WIDTH(64),
             .MAX_OUTPUT_TOKENS(MAXT), .TOKENS_ADDR(BASE)) dut (
      .clk(clk), .resetn(resetn), .START(START), .IDLE(IDLE), .DONE(DONE), .ERROR(ERROR),
      .FIFO_DATA(FIFO_DATA), .FIFO_WR_EN(FIFO_WR_EN), .FIFO_FULL(FIFO_FULL),
      .FIFO_COUNT(FIFO_COUNT), .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID),
      .AXI_AWLEN(AXI_AWLEN), .AXI_AWSIZE(AXI_AWSIZE), .AXI_AWBURST(AXI_AWBURST),
      .AXI_AWID(AXI_AWID), .AXI_AWCACHE(AXI_AWCACHE), .AXI_AWPROT(AXI_AWPROT),
      .AXI_AWLOCK(AXI_AWLOCK), .AXI_AWQOS(AXI_AWQOS), .AXI_AWREADY(AXI_AWREADY),
      .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID),
      .AXI_WLAST(AXI_WLAST), .AXI_WREADY(AXI_WREADY), .AXI_BRESP(AXI_BRESP),
      .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY));

   always #5 clk = ~clk;

   int          vectors = 0, miscompares = 0;
   int          mode = 0;          // 0 all ready, 1 random, 2 slow AW + toggling W, 3 W stalled
   int          aw_wait = 0;
   logic [1:0]  bresp_cfg = 0;
   logic [TW-1:0] q[$];            // tokens queued and not yet assigned to a burst
   int          in_flight = 0;     // payload beats assigned to a burst but not yet sent
   int          exp_aw[$];
   logic [32:0] exp_w[$];
   bit          aw_seen = 0, stall_v = 0, done_exp = 0, err_exp = 0;
   bit          b_pending = 0, b_hs = 0;
   logic [32:0] stall_d = '0;
   int          done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Ready generation and B-channel responder
   always @(posedge clk) begin
      #1;
      case (mode)
         0: begin AXI_AWREADY = 1; AXI_WREADY = 1; end
         1: begin AXI_AWREADY = 1'($urandom % 2); AXI_WREADY = 1'($urandom % 2); end
         2: begin
            aw_wait = AXI_AWVALID ? aw_wait + 1 : 0;
            AXI_AWREADY = (aw_wait >= 5);
            AXI_WREADY  = !AXI_WREADY;
         end
         default: begin AXI_AWREADY = 1; AXI_WREADY = 0; end
      endcase
      if (!resetn) begin
         AXI_BVALID = 0; b_pending = 0; b_hs = 0;
      end else if (b_hs) begin
         AXI_BVALID = 0; b_hs = 0;
      end else if (b_pending && (mode == 0 || ($urandom % 2) == 1)) begin
         AXI_BVALID = 1; AXI_BRESP = bresp_cfg; b_pending = 0;
      end
   end

   // Monitor: every handshake is decided by values stable at the negedge
   always @(negedge clk) begin
      if (!resetn) begin
         aw_seen = 0; stall_v = 0; done_exp = 0;
      end else begin
         chk("done_pulse", 64'(DONE), 64'(done_exp));
         if (done_exp) begin
            chk("error_flag", 64'(ERROR), 64'(err_exp));
            chk("idle_with_done", 64'(IDLE), 64'd1);
            done_cnt++;
         end
         done_exp = 0;
         if (stall_v) chk("w_stable", 64'({AXI_WVALID, AXI_WLAST, AXI_WDATA}), 64'({1'b1, stall_d}));
         if (mode == 0 && aw_seen) chk("w_back_to_back", 64'(AXI_WVALID), 64'd1);
         if (AXI_WVALID && !aw_seen) chk("w_before_aw", 64'(AXI_WVALID), 64'd0);
         if (AXI_AWVALID && AXI_AWREADY) begin
            if (exp_aw.size() == 0) chk("aw_unexpected", 64'(AXI_AWLEN), 64'hFFFF);
            else begin
               chk("awlen", 64'(AXI_AWLEN), 64'(exp_aw.pop_front()));
               chk("awaddr", AXI_AWADDR, BASE);
            end
            aw_seen = 1;
         end
         if (AXI_WVALID && AXI_WREADY) begin
            if (exp_w.size() == 0) chk("w_unexpected", 64'(AXI_WDATA), 64'hFFFF_FFFF_FFFF);
            else chk("wbeat", 64'({AXI_WLAST, AXI_WDATA}), 64'(exp_w.pop_front()));
            if (AXI_WLAST) begin aw_seen = 0; b_pending = 1; end
            else in_flight--;
         end
         stall_v = AXI_WVALID && !AXI_WREADY;
         stall_d = {AXI_WLAST, AXI_WDATA};
         if (AXI_BVALID && AXI_BREADY) begin
            done_exp = 1; err_exp = (AXI_BRESP != 2'b00); b_hs = 1;
         end
      end
   end

   task automatic push(input logic [TW-1:0] v);
      @(posedge clk); #1;
      FIFO_DATA = v; FIFO_WR_EN = 1;
      if (v != 0 && q.size() + in_flight < DEPTH) q.push_back(v);
      @(posedge clk); #1;
      FIFO_WR_EN = 0;
   endtask

   task automatic start_burst(input bit chk_lat);
      int n;
      @(posedge clk); #1;
      n = (q.size() > MAXT - 1) ? MAXT - 1 : q.size();
      exp_aw.push_back(n);
      for (int i = 0; i < n; i++) exp_w.push_back({1'b0, q.pop_front()});
      exp_w.push_back({1'b1, 32'h0});
      in_flight = n;
      START = 1;
      @(posedge clk); #1;
      START = 0;
      if (chk_lat) chk("awvalid_latency", 64'(AXI_AWVALID), 64'd1);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1; START = 1;
      @(posedge clk); #1; START = 0;
   endtask

   task automatic wait_done();
      int c0 = done_cnt;
      int t  = 0;
      while (done_cnt == c0 && t < 3000) begin @(posedge clk); t++; end
      if (done_cnt == c0) chk("done_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic chk_count(input string name);
      @(negedge clk);
      chk(name, 64'(FIFO_COUNT), 64'(q.size() + in_flight));
   endtask

   initial begin
      int t;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_idle", 64'(IDLE), 64'd1);
      chk("rst_count", 64'(FIFO_COUNT), 64'd0);
      chk("rst_full", 64'(FIFO_FULL), 64'd0);
      chk("rst_valids", 64'({AXI_AWVALID, AXI_WVALID, AXI_BREADY, DONE, ERROR}), 64'd0);
      chk("rst_awlen", 64'(AXI_AWLEN), 64'd0);
      chk("aw_consts", 64'({AXI_AWSIZE, AXI_AWBURST, AXI_AWID, AXI_AWCACHE, AXI_AWPROT,
                            AXI_AWLOCK, AXI_AWQOS, AXI_WSTRB}),
          64'({3'd2, 2'd1, 4'd1, 4'd2, 3'd0, 1'b0, 4'd0, 4'hF}));
      @(posedge clk); #1; resetn = 1;

      // basic three-token message
      mode = 0;
      push(32'hA); push(32'hB); push(32'hC);
      start_burst(1); wait_done(); chk_count("count_after_abc");
      // empty FIFO: terminator only
      start_burst(1); wait_done(); chk_count("count_after_empty");
      // burst capped at MAXT-1 payload beats
      for (int i = 1; i <= 10; i++) push(32'(i));
      start_burst(0); wait_done(); chk_count("count_after_cap");
      start_burst(0); wait_done(); chk_count("count_after_rest");

      // slow slave, late push and stray START during the burst
      mode = 2;
      push(32'h11); push(32'h22); push(32'h33);
      start_burst(0);
      pulse_start();
      push(32'h55);
      wait_done(); chk_count("count_after_midpush");
      mode = 0;
      start_burst(0); wait_done(); chk_count("count_after_drain55");

      // zero tokens and writes while full are dropped
      push(32'h0); chk_count("count_after_zero_push");
      for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i));
      push(32'h777); push(32'h0);
      chk_count("count_full");
      chk("full_flag", 64'(FIFO_FULL), 64'd1);
      for (int i = 0; i < 3; i++) begin start_burst(0); wait_done(); end
      chk_count("count_after_full_drain");

      // error response
      bresp_cfg = 2'b10;
      push(32'h9); start_burst(0); wait_done();
      @(negedge clk); chk("error_sticky", 64'(ERROR), 64'd1);
      bresp_cfg = 2'b00;
      start_burst(0); wait_done();
      @(negedge clk); chk("error_cleared", 64'(ERROR), 64'd0);

      // reset while W is stalled
      mode = 3;
      push(32'h21); push(32'h22); push(32'h23);
      start_burst(0);
      t = 0;
      while (!AXI_WVALID && t < 100) begin @(posedge clk); #1; t++; end
      chk("wvalid_before_reset", 64'(AXI_WVALID), 64'd1);
      @(posedge clk); #1; resetn = 0;
      @(posedge clk); @(negedge clk);
      chk("rst_mid_wvalid", 64'(AXI_WVALID), 64'd0);
      chk("rst_mid_idle", 64'(IDLE), 64'd1);
      chk("rst_mid_count", 64'(FIFO_COUNT), 64'd0);
      q.delete(); exp_w.delete(); exp_aw.delete(); in_flight = 0;
      @(posedge clk); #1; resetn = 1;

      // randomized traffic
      for (int it = 0; it < 25; it++) begin
         int np;
         mode = ($urandom % 2 == 0) ? 0 : 1;
         bresp_cfg = 2'($urandom % 4);
         np = $urandom_range(0, 10);
         for (int k = 0; k < np; k++)
            push(($urandom_range(0, 4) == 0) ? 32'h0 : $urandom);
         start_burst(0);
         wait_done();
         chk_count("count_random");
      end

      chk("leftover_beats", 64'(exp_w.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
